// File: rtl/manchester_decoder.sv
// manchester_decoder: recovers pair alignment on a Manchester line (one half-bit per clk), decodes bits, flags violations, packs MSB-first words
// Ports: clk, rst_n (async active-low) | z_in line | bit_out/bit_valid decoded bit | word_out/word_valid assembled word
//        locked alignment established | code_err violation while locked | err_count saturating violation count
//        (err_count exists only when MANCHESTER_DEC_ERRCNT_EN is defined)
module manchester_decoder #(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             z_in,
    output logic             bit_out,
    output logic             bit_valid,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             locked,
    output logic             code_err
`ifdef MANCHESTER_DEC_ERRCNT_EN
    ,
    output logic [7:0]       err_count
`endif
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {HUNT, LOCKED} state_t;
    state_t           state_q, state_d;
    logic             z_q, first_q, first_d, phase_q, phase_d, pend_q, pend_d;
    logic [3:0]       good_cnt_q, good_cnt_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d, word_q, word_d, shifted;
    logic             bit_q, bit_d, bit_valid_q, bit_valid_d;
    logic             word_valid_q, word_valid_d, code_err_q, code_err_d;
    logic             valid, slip, cur_phase;
`ifdef MANCHESTER_DEC_ERRCNT_EN
    logic [7:0]       err_cnt_q, err_cnt_d;
`endif
    always_comb begin
        valid     = first_q ^ z_q;
        // pend_q: z_q holds a second half and first_q its first half, so the pair is evaluated now
        slip      = pend_q & ~valid;
        // a slip reuses the just-captured second half as the next first half
        cur_phase = slip | phase_q;
        first_d   = cur_phase ? z_q : first_q;
        pend_d    = cur_phase;
        phase_d   = ~cur_phase;
        shifted   = {shift_q[WIDTH-2:0], first_q};
        state_d      = state_q;
        good_cnt_d   = good_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        word_d       = word_q;
        bit_d        = bit_q;
        bit_valid_d  = 1'b0;
        word_valid_d = 1'b0;
        code_err_d   = 1'b0;
        if (pend_q) begin
            if (state_q == HUNT) begin
                good_cnt_d = valid ? good_cnt_q + 4'd1 : 4'd0;
                if (valid && (good_cnt_q + 4'd1) == 4'(LOCK_COUNT)) begin
                    state_d    = LOCKED;
                    good_cnt_d = 4'd0;
                    bit_cnt_d  = '0;
                end
            end else if (valid) begin
                bit_valid_d = 1'b1;
                bit_d       = first_q;
                shift_d     = shifted;
                bit_cnt_d   = (bit_cnt_q == CW'(WIDTH-1)) ? '0 : bit_cnt_q + 1'b1;
                if (bit_cnt_q == CW'(WIDTH-1)) begin
                    word_d       = shifted;
                    word_valid_d = 1'b1;
                end
            end else begin
                // violation while locked: drop the partial word and re-hunt
                code_err_d = 1'b1;
                state_d    = HUNT;
                good_cnt_d = 4'd0;
                bit_cnt_d  = '0;
            end
        end
`ifdef MANCHESTER_DEC_ERRCNT_EN
        err_cnt_d = err_cnt_q + {7'd0, code_err_d & (err_cnt_q != 8'hFF)};
`endif
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            z_q          <= 1'b0;
            first_q      <= 1'b0;
            phase_q      <= 1'b0;
            pend_q       <= 1'b0;
            good_cnt_q   <= 4'd0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            word_q       <= '0;
            bit_q        <= 1'b0;
            bit_valid_q  <= 1'b0;
            word_valid_q <= 1'b0;
            code_err_q   <= 1'b0;
`ifdef MANCHESTER_DEC_ERRCNT_EN
            err_cnt_q    <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            z_q          <= z_in;
            first_q      <= first_d;
            phase_q      <= phase_d;
            pend_q       <= pend_d;
            good_cnt_q   <= good_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            bit_q        <= bit_d;
            bit_valid_q  <= bit_valid_d;
            word_valid_q <= word_valid_d;
            code_err_q   <= code_err_d;
`ifdef MANCHESTER_DEC_ERRCNT_EN
            err_cnt_q    <= err_cnt_d;
`endif
        end
    end
    assign bit_out    = bit_q;
    assign bit_valid  = bit_valid_q;
    assign word_out   = word_q;
    assign word_valid = word_valid_q;
    assign locked     = (state_q == LOCKED);
    assign code_err   = code_err_q;
`ifdef MANCHESTER_DEC_ERRCNT_EN
    assign err_count  = err_cnt_q;
`endif
endmodule

// File: tb/tb_manchester_decoder.sv
// tb_manchester_decoder: directed scoreboard bench for manchester_decoder (WIDTH=8, LOCK_COUNT=4)
module tb_manchester_decoder;
    localparam int W = 8;
    logic         clk = 1'b0, rst_n = 1'b0, z_in = 1'b0;
    logic         bit_out, bit_valid, word_valid, locked, code_err;
    logic [W-1:0] word_out;
`ifdef MANCHESTER_DEC_ERRCNT_EN
    logic [7:0]   err_count;
`endif
    int           total = 0, bad = 0, n_wv = 0, n_ce = 0;
    logic         bq[$];
    logic [W-1:0] wq[$];
    always #5 clk = ~clk;
    manchester_decoder #(.WIDTH(W), .LOCK_COUNT(4)) dut (
        .clk(clk), .rst_n(rst_n), .z_in(z_in), .bit_out(bit_out), .bit_valid(bit_valid),
        .word_out(word_out), .word_valid(word_valid), .locked(locked), .code_err(code_err)
`ifdef MANCHESTER_DEC_ERRCNT_EN
        , .err_count(err_count)
`endif
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // one clock, then score any pulses against the queues
    task automatic tick();
        logic         b;
        logic [W-1:0] w;
        @(posedge clk);
        #1;
        if (bit_valid) begin
            chk("bit_expected", 32'(bq.size() > 0), 32'd1);
            if (bq.size() > 0) begin
                b = bq.pop_front();
                chk("bit_out", 32'(bit_out), 32'(b));
            end
        end
        if (word_valid) begin
            n_wv++;
            chk("word_expected", 32'(wq.size() > 0), 32'd1);
            if (wq.size() > 0) begin
                w = wq.pop_front();
                chk("word_out", 32'(word_out), 32'(w));
            end
        end
        if (code_err) n_ce++;
    endtask
    task automatic send_half(input logic b);
        z_in = b;
        tick();
    endtask
    task automatic preamble(input int from, input int to);
        for (int i = from; i < to; i++) begin
            send_half(i[0]);
            send_half(~i[0]);
        end
    endtask
    task automatic send_bits(input logic [31:0] v, input int n, input bit lk, input bit pw);
        for (int i = n - 1; i >= 0; i--) begin
            bq.push_back(v[i]);
            if (pw && i == 0) wq.push_back(v[W-1:0]);
            send_half(v[i]);
            if (lk && i == n - 1) chk("lock_rise", 32'(locked), 32'd1);
            send_half(~v[i]);
        end
    endtask
    task automatic chk_reset(input string tag);
        chk({tag, "_bit_out"}, 32'(bit_out), 32'd0);
        chk({tag, "_bit_valid"}, 32'(bit_valid), 32'd0);
        chk({tag, "_word_out"}, 32'(word_out), 32'd0);
        chk({tag, "_word_valid"}, 32'(word_valid), 32'd0);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_code_err"}, 32'(code_err), 32'd0);
`ifdef MANCHESTER_DEC_ERRCNT_EN
        chk({tag, "_err_count"}, 32'(err_count), 32'd0);
`endif
    endtask
    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask
    initial begin
        #12;
        chk_reset("rst");
        release_reset();
        preamble(0, 4);
        chk("lock_early", 32'(locked), 32'd0);
        send_bits(32'hA5, 8, 1'b1, 1'b1);
        send_bits(32'b111001, 6, 1'b0, 1'b0);
        chk("word_count_a5", 32'(n_wv), 32'd1);
        chk("word_hold_a5", 32'(word_out), 32'hA5);
        // violation on a partial word, then relock from the slipped phase
        send_half(1'b1);
        send_half(1'b1);
        send_half(1'b0);
        chk("viol1_code_err", 32'(code_err), 32'd1);
        chk("viol1_unlocked", 32'(locked), 32'd0);
        chk("viol1_bits_drained", 32'(bq.size()), 32'd0);
        send_half(1'b1);
        preamble(1, 5);
        chk("viol1_one_pulse", 32'(n_ce), 32'd1);
        chk("viol1_word_kept", 32'(word_out), 32'hA5);
`ifdef MANCHESTER_DEC_ERRCNT_EN
        chk("viol1_err_count", 32'(err_count), 32'd1);
`endif
        chk("relock1_early", 32'(locked), 32'd0);
        send_bits(32'h3C, 8, 1'b1, 1'b1);
        // violation on the pair that would complete a word
        send_bits(32'h1E, 7, 1'b0, 1'b0);
        send_half(1'b1);
        send_half(1'b1);
        send_half(1'b0);
        chk("viol2_code_err", 32'(code_err), 32'd1);
        chk("viol2_no_word", 32'(word_valid), 32'd0);
        chk("viol2_unlocked", 32'(locked), 32'd0);
        send_half(1'b1);
        preamble(1, 5);
        chk("viol2_words", 32'(n_wv), 32'd2);
        chk("viol2_pulses", 32'(n_ce), 32'd2);
        chk("viol2_word_kept", 32'(word_out), 32'h3C);
`ifdef MANCHESTER_DEC_ERRCNT_EN
        chk("viol2_err_count", 32'(err_count), 32'd2);
`endif
        chk("relock2_early", 32'(locked), 32'd0);
        send_bits(32'b10110, 5, 1'b1, 1'b0);
        // asynchronous reset mid-word
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        bq.delete();
        release_reset();
        preamble(0, 4);
        chk("rerst_lock_early", 32'(locked), 32'd0);
        send_bits(32'h5A, 8, 1'b1, 1'b1);
        tick();
        chk("rerst_word", 32'(word_out), 32'h5A);
        // misaligned start: one idle half before the preamble
        rst_n = 1'b0;
        #1;
        release_reset();
        send_half(1'b0);
        preamble(0, 4);
        chk("mis_lock_early", 32'(locked), 32'd0);
        send_bits(32'hC3, 8, 1'b1, 1'b1);
        tick();
        chk("mis_word", 32'(word_out), 32'hC3);
        chk("total_words", 32'(n_wv), 32'd4);
        chk("bits_left", 32'(bq.size()), 32'd0);
        chk("words_left", 32'(wq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
